// File: rtl/vector_compare.sv
// Streaming vector checker: compares count words at x_base against y_base and
// reports mismatch statistics. Optional macro: VECTOR_COMPARE_EARLY_EXIT_EN.
module vector_compare #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] x_base,
  input  logic [ADDR_WIDTH-1:0] y_base,
  input  logic [DATA_WIDTH-1:0] count,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] raddr1,
  output logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  ren,
  input  logic [DATA_WIDTH-1:0] rdata1,
  input  logic [DATA_WIDTH-1:0] rdata2,
  output logic                  idle,
  output logic                  done,
  output logic                  pass,
  output logic [DATA_WIDTH-1:0] mismatch_count,
  output logic [DATA_WIDTH-1:0] first_mismatch_idx,
  output logic                  first_mismatch_valid
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [DATA_WIDTH-1:0] D_ONE = DATA_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr1_reg, addr1_next;
  logic [ADDR_WIDTH-1:0] addr2_reg, addr2_next;
  logic [DATA_WIDTH-1:0] remaining_reg, remaining_next;
  logic [DATA_WIDTH-1:0] idx_reg, idx_next;
  logic [DATA_WIDTH-1:0] mismatch_count_reg, mismatch_count_next;
  logic [DATA_WIDTH-1:0] first_idx_reg, first_idx_next;
  logic                  first_valid_reg, first_valid_next;
  logic                  mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      addr1_reg          <= '0;
      addr2_reg          <= '0;
      remaining_reg      <= '0;
      idx_reg            <= '0;
      mismatch_count_reg <= '0;
      first_idx_reg      <= '0;
      first_valid_reg    <= 1'b0;
    end else begin
      state_reg          <= state_next;
      addr1_reg          <= addr1_next;
      addr2_reg          <= addr2_next;
      remaining_reg      <= remaining_next;
      idx_reg            <= idx_next;
      mismatch_count_reg <= mismatch_count_next;
      first_idx_reg      <= first_idx_next;
      first_valid_reg    <= first_valid_next;
    end
  end

  assign mismatch = (rdata1 != rdata2);

  always_comb begin
    state_next          = state_reg;
    addr1_next          = addr1_reg;
    addr2_next          = addr2_reg;
    remaining_next      = remaining_reg;
    idx_next            = idx_reg;
    mismatch_count_next = mismatch_count_reg;
    first_idx_next      = first_idx_reg;
    first_valid_next    = first_valid_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          addr1_next          = x_base;
          addr2_next          = y_base;
          remaining_next      = count;
          idx_next            = '0;
          mismatch_count_next = '0;
          first_valid_next    = 1'b0;
          state_next          = (count != '0) ? RUN : FIN;
        end
      end
      RUN: begin
        if (mismatch) begin
          if (mismatch_count_reg != '1)
            mismatch_count_next = mismatch_count_reg + D_ONE;
          if (!first_valid_reg) begin
            first_idx_next   = idx_reg;
            first_valid_next = 1'b1;
          end
        end
        addr1_next     = addr1_reg + A_ONE;
        addr2_next     = addr2_reg + A_ONE;
        idx_next       = idx_reg + D_ONE;
        remaining_next = remaining_reg - D_ONE;
        if (remaining_reg == D_ONE)
          state_next = FIN;
`ifdef VECTOR_COMPARE_EARLY_EXIT_EN
        // Stop reading as soon as the verdict is known.
        if (mismatch)
          state_next = FIN;
`endif
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign raddr1               = addr1_reg;
  assign raddr2               = addr2_reg;
  assign ren                  = (state_reg == RUN);
  assign idle                 = (state_reg == IDLE);
  assign done                 = (state_reg == FIN);
  assign pass                 = (state_reg == FIN) && (mismatch_count_reg == '0);
  assign mismatch_count       = mismatch_count_reg;
  assign first_mismatch_idx   = first_idx_reg;
  assign first_mismatch_valid = first_valid_reg;

endmodule
